// File: rtl/gate_tt_checker.sv
// ---------------------------------------------------------------------------
// gate_tt_checker
//
// Drives a 2-input gate under test. It applies each of the four {a,b} vectors
// for SETTLE cycles and samples the gate output on the last cycle of each
// vector. Each sample is compared with the TRUTH table. The sweep is repeated
// PASSES times. At the end of the run the block reports a saturating
// mismatch count and a pass/fail flag.
//
// Parameters
//   TRUTH   expected gate output per vector; bit index = {a,b}
//   SETTLE  cycles each vector is held (>= 1); sample taken on the last one
//   PASSES  number of full 4-vector sweeps per run (>= 1)
//   ERR_W   width of the mismatch counter
//
// Ports
//   i_clk       clock, rising edge
//   i_rst_n     synchronous reset, active-low
//   i_start     run request, honoured only while idle
//   i_y         output of the gate under test
//   o_a, o_b    gate stimulus (o_a drives gate input i_1, o_b drives i_2)
//   o_busy      high while sweeping
//   o_done      one-cycle pulse at end of run
//   o_pass      1 = zero mismatches in last run; held until next start
//   o_err_cnt   mismatches in last run (saturating); held until next start
//
// Optional feature, macro GATE_CHK_FIRST_FAIL_EN:
//   o_fail_vld  a mismatch was seen in this run
//   o_fail_vec  {a,b} of the first mismatching vector in this run
// ---------------------------------------------------------------------------
module gate_tt_checker #(
  parameter logic [3:0] TRUTH  = 4'b1000,
  parameter int         SETTLE = 2,
  parameter int         PASSES = 1,
  parameter int         ERR_W  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_y,
  output logic             o_a,
  output logic             o_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
`ifdef GATE_CHK_FIRST_FAIL_EN
  output logic             o_fail_vld,
  output logic [1:0]       o_fail_vec,
`endif
  output logic [ERR_W-1:0] o_err_cnt
);

  localparam int CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PCNT_W = (PASSES > 1) ? $clog2(PASSES) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SETTLE - 1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PASSES - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q,   state_d;
  logic [1:0]         vec_q,     vec_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [PCNT_W-1:0]  pcnt_q,    pcnt_d;
  logic [ERR_W-1:0]   err_q,     err_d;
  logic               pass_q,    pass_d;
`ifdef GATE_CHK_FIRST_FAIL_EN
  logic               fvld_q,    fvld_d;
  logic [1:0]         fvec_q,    fvec_d;
`endif

  logic mismatch;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    pcnt_d   = pcnt_q;
    err_d    = err_q;
    pass_d   = pass_q;
    mismatch = 1'b0;
`ifdef GATE_CHK_FIRST_FAIL_EN
    fvld_d   = fvld_q;
    fvec_d   = fvec_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_RUN;
          vec_d   = 2'd0;
          cnt_d   = '0;
          pcnt_d  = '0;
          err_d   = '0;
          pass_d  = 1'b0;
`ifdef GATE_CHK_FIRST_FAIL_EN
          fvld_d  = 1'b0;
          fvec_d  = 2'd0;
`endif
        end
      end

      ST_RUN: begin
        if (cnt_q == CNT_LAST) begin
          // Last settle cycle of this vector: sample the gate output.
          cnt_d    = '0;
          mismatch = (i_y != TRUTH[vec_q]);
          if (mismatch && (err_q != ERR_MAX)) begin
            err_d = err_q + 1'b1;
          end
`ifdef GATE_CHK_FIRST_FAIL_EN
          if (mismatch && !fvld_q) begin
            fvld_d = 1'b1;
            fvec_d = vec_q;
          end
`endif
          // vec wraps 3->0, so the stimulus returns to 00 for DONE and IDLE.
          vec_d = vec_q + 2'd1;
          if (vec_q == 2'd3) begin
            pcnt_d = pcnt_q + 1'b1;
            if (pcnt_q == PCNT_LAST) begin
              state_d = ST_DONE;
              // Uses the count that already includes this last compare.
              pass_d  = (err_d == '0);
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= 2'd0;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
`ifdef GATE_CHK_FIRST_FAIL_EN
      fvld_q  <= 1'b0;
      fvec_q  <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
`ifdef GATE_CHK_FIRST_FAIL_EN
      fvld_q  <= fvld_d;
      fvec_q  <= fvec_d;
`endif
    end
  end

  // All outputs are decodes of registers, so they are glitch-free per cycle.
  assign o_a       = vec_q[1];
  assign o_b       = vec_q[0];
  assign o_busy    = (state_q == ST_RUN);
  assign o_done    = (state_q == ST_DONE);
  assign o_pass    = pass_q;
  assign o_err_cnt = err_q;
`ifdef GATE_CHK_FIRST_FAIL_EN
  assign o_fail_vld = fvld_q;
  assign o_fail_vec = fvec_q;
`endif

endmodule

// File: tb/tb_gate_tt_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_tt_checker
//
// Directed bench for gate_tt_checker. The main instance uses the default
// parameters (AND truth table, SETTLE=2, PASSES=1). It drives a
// behavioural gate whose function is chosen per test. A second instance
// uses PASSES=6 with its gate output tied high, to make the mismatch counter
// saturate.
// ---------------------------------------------------------------------------
module tb_gate_tt_checker;

  localparam int SEL_AND = 0;
  localparam int SEL_OR  = 1;

  logic clk;
  logic rst_n;

  // Main instance
  logic       start;
  logic       y;
  logic       a, b, busy, done, pass;
  logic [3:0] err_cnt;
  int         gate_sel;

  // Saturation instance
  logic       s_start;
  logic       s_a, s_b, s_busy, s_done, s_pass;
  logic [3:0] s_err_cnt;

`ifdef GATE_CHK_FIRST_FAIL_EN
  logic       fail_vld, s_fail_vld;
  logic [1:0] fail_vec, s_fail_vec;
`endif

  int passed;
  int total;

  // Trace of the {a,b} stimulus on each busy cycle of the last main run.
  logic [1:0] ab_trace [0:63];
  logic [1:0] done_ab;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural gate under test
  assign y = (gate_sel == SEL_OR) ? (a | b) : (a & b);

  gate_tt_checker dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_y       (y),
    .o_a       (a),
    .o_b       (b),
    .o_busy    (busy),
    .o_done    (done),
    .o_pass    (pass),
`ifdef GATE_CHK_FIRST_FAIL_EN
    .o_fail_vld(fail_vld),
    .o_fail_vec(fail_vec),
`endif
    .o_err_cnt (err_cnt)
  );

  gate_tt_checker #(
    .TRUTH (4'b1000),
    .SETTLE(2),
    .PASSES(6),
    .ERR_W (4)
  ) dut_sat (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (s_start),
    .i_y       (1'b1),
    .o_a       (s_a),
    .o_b       (s_b),
    .o_busy    (s_busy),
    .o_done    (s_done),
    .o_pass    (s_pass),
`ifdef GATE_CHK_FIRST_FAIL_EN
    .o_fail_vld(s_fail_vld),
    .o_fail_vec(s_fail_vec),
`endif
    .o_err_cnt (s_err_cnt)
  );

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a run on the main instance and follows it until o_done, bounded.
  task automatic run_main(input bit hold_start, output int busy_cyc,
                          output bit saw_done);
    start = 1'b1;
    step();
    if (!hold_start) start = 1'b0;
    busy_cyc = 0;
    saw_done = 1'b0;
    for (int i = 0; i < 200 && !saw_done; i++) begin
      if (busy) begin
        if (busy_cyc < 64) ab_trace[busy_cyc] = {a, b};
        busy_cyc++;
      end
      if (done) begin
        saw_done = 1'b1;
        done_ab  = {a, b};
      end
      if (!saw_done) step();
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    start   = 1'b0;
    s_start = 1'b0;
    step();
    step();
    total++;
    if ({a, b, busy, done, pass, err_cnt} !== 9'b0) begin
      $display("FAIL reset_main: got a,b,busy,done,pass,err=%b want 0", {a, b, busy, done, pass, err_cnt});
    end else passed++;
    total++;
    if ({s_a, s_b, s_busy, s_done, s_pass, s_err_cnt} !== 9'b0) begin
      $display("FAIL reset_sat: got %b want 0", {s_a, s_b, s_busy, s_done, s_pass, s_err_cnt});
    end else passed++;
`ifdef GATE_CHK_FIRST_FAIL_EN
    total++;
    if ({fail_vld, fail_vec} !== 3'b0) begin
      $display("FAIL reset_fail_capture: got %b want 000", {fail_vld, fail_vec});
    end else passed++;
`endif
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_and_pass();
    int bc;
    bit sd;
    gate_sel = SEL_AND;
    run_main(1'b0, bc, sd);
    total++;
    if (sd !== 1'b1) $display("FAIL and_done_seen: got %0b want 1", sd);
    else passed++;
    total++;
    if (bc != 8) $display("FAIL and_busy_cycles: got %0d want 8", bc);
    else passed++;
    total++;
    if (err_cnt !== 4'd0) $display("FAIL and_err_cnt: got %0d want 0", err_cnt);
    else passed++;
    total++;
    if (pass !== 1'b1) $display("FAIL and_pass: got %b want 1", pass);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL and_busy_in_done: got %b want 0", busy);
    else passed++;
`ifdef GATE_CHK_FIRST_FAIL_EN
    total++;
    if (fail_vld !== 1'b0) $display("FAIL and_fail_vld: got %b want 0", fail_vld);
    else passed++;
`endif
    step();
    total++;
    if (done !== 1'b0) $display("FAIL and_done_one_cycle: got %b want 0", done);
    else passed++;
  endtask

  task automatic test_vector_sweep();
    int bc;
    bit sd;
    logic [1:0] exp_ab [0:7];
    exp_ab = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
    gate_sel = SEL_AND;
    run_main(1'b0, bc, sd);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (ab_trace[i] !== exp_ab[i]) begin
        $display("FAIL sweep_ab[%0d]: got %b want %b", i, ab_trace[i], exp_ab[i]);
      end else passed++;
    end
    total++;
    if (done_ab !== 2'b00) $display("FAIL sweep_ab_done: got %b want 00", done_ab);
    else passed++;
    step();
  endtask

  task automatic test_or_mismatch();
    int bc;
    bit sd;
    gate_sel = SEL_OR;
    run_main(1'b0, bc, sd);
    total++;
    if (sd !== 1'b1) $display("FAIL or_done_seen: got %0b want 1", sd);
    else passed++;
    total++;
    if (err_cnt !== 4'd2) $display("FAIL or_err_cnt: got %0d want 2", err_cnt);
    else passed++;
    total++;
    if (pass !== 1'b0) $display("FAIL or_pass: got %b want 0", pass);
    else passed++;
`ifdef GATE_CHK_FIRST_FAIL_EN
    total++;
    if ({fail_vld, fail_vec} !== 3'b101) begin
      $display("FAIL or_first_fail: got vld,vec=%b want 101", {fail_vld, fail_vec});
    end else passed++;
`endif
    // The results must hold in IDLE until the next start.
    for (int i = 0; i < 4; i++) step();
    total++;
    if ({busy, done, pass, err_cnt} !== 7'b000_0010) begin
      $display("FAIL or_results_held: got busy,done,pass,err=%b want 0000010", {busy, done, pass, err_cnt});
    end else passed++;
  endtask

  task automatic test_saturation();
    int bc;
    bit sd;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    bc = 0;
    sd = 1'b0;
    for (int i = 0; i < 300 && !sd; i++) begin
      if (s_busy) bc++;
      if (s_done) sd = 1'b1;
      else step();
    end
    total++;
    if (sd !== 1'b1) $display("FAIL sat_done_seen: got %0b want 1", sd);
    else passed++;
    total++;
    if (bc != 48) $display("FAIL sat_busy_cycles: got %0d want 48", bc);
    else passed++;
    total++;
    if (s_err_cnt !== 4'd15) $display("FAIL sat_err_cnt: got %0d want 15", s_err_cnt);
    else passed++;
    total++;
    if (s_pass !== 1'b0) $display("FAIL sat_pass: got %b want 0", s_pass);
    else passed++;
`ifdef GATE_CHK_FIRST_FAIL_EN
    total++;
    if ({s_fail_vld, s_fail_vec} !== 3'b100) begin
      $display("FAIL sat_first_fail: got vld,vec=%b want 100", {s_fail_vld, s_fail_vec});
    end else passed++;
`endif
    step();
  endtask

  task automatic test_reset_mid_run();
    int bc;
    bit sd;
    bit done_seen;
    gate_sel = SEL_AND;
    start = 1'b1;
    step();              // first busy cycle
    start = 1'b0;
    step();              // second busy cycle
    step();              // third busy cycle
    total++;
    if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", busy);
    else passed++;
    rst_n = 1'b0;
    step();
    total++;
    if ({a, b, busy, done, pass, err_cnt} !== 9'b0) begin
      $display("FAIL midrst_outputs: got %b want 0", {a, b, busy, done, pass, err_cnt});
    end else passed++;
    rst_n = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done || busy) done_seen = 1'b1;
    end
    total++;
    if (done_seen !== 1'b0) $display("FAIL midrst_no_done: got activity=%b want 0", done_seen);
    else passed++;
    run_main(1'b0, bc, sd);
    total++;
    if ({sd, pass, err_cnt} !== 6'b11_0000 || bc != 8) begin
      $display("FAIL midrst_restart: got done,pass,err=%b busy=%0d want 110000 busy=8", {sd, pass, err_cnt}, bc);
    end else passed++;
    step();
  endtask

  task automatic test_start_held();
    int bc;
    bit sd;
    gate_sel = SEL_AND;
    run_main(1'b1, bc, sd);   // start stays high throughout
    total++;
    if (sd !== 1'b1 || bc != 8) begin
      $display("FAIL held_first_run: got done=%0b busy=%0d want done=1 busy=8", sd, bc);
    end else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL held_busy_in_done: got %b want 0", busy);
    else passed++;
    step();                   // IDLE re-entered, start sampled here
    total++;
    if ({busy, done} !== 2'b00) $display("FAIL held_idle_cycle: got busy,done=%b want 00", {busy, done});
    else passed++;
    step();
    total++;
    if (busy !== 1'b1) $display("FAIL held_restart: got busy=%b want 1", busy);
    else passed++;
    start = 1'b0;
    sd = 1'b0;
    for (int i = 0; i < 50 && !sd; i++) begin
      if (done) sd = 1'b1;
      else step();
    end
    total++;
    if (sd !== 1'b1) $display("FAIL held_second_done: got %0b want 1", sd);
    else passed++;
    step();
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    gate_sel = SEL_AND;
    start    = 1'b0;
    s_start  = 1'b0;
    rst_n    = 1'b0;
    test_reset();
    test_and_pass();
    test_vector_sweep();
    test_or_mismatch();
    test_saturation();
    test_reset_mid_run();
    test_start_held();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
